spi_tx_fifo: RTL and testbench
==============================

# spi_tx_fifo

Buffers 24-bit SPI frames between the register/command logic and the `spi_tx` serializer. It accepts words on a valid/ready input and holds them in a small synchronous FIFO. It drains them one at a time into `spi_tx` through the `BUS_DATA`/`tx_valid`/`spi_ready` handshake. This lets the producer queue a burst of up to DEPTH frames, for example a DAC init sequence, without waiting for each frame to finish on the wire.

## Interface
Parameters:
- `DEPTH`, default 8: storage entries; must be a power of two and ≥ 2.
- `DW`, default 24: frame width; must match the `spi_tx` `BUS_DATA` width.

Ports:
- `clk` in 1: system clock (50 MHz).
- `RST` in 1: reset, synchronous and active-high.
- `in_data` in DW: frame from the producer.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: FIFO can accept a word this cycle.
- `flush` in 1: synchronous clear of all queued words.
- `BUS_DATA` out DW: head-of-queue frame, wired to `spi_tx.BUS_DATA`.
- `tx_valid` out 1: head frame is valid, wired to `spi_tx.tx_valid`.
- `spi_ready` in 1: from `spi_tx`; high while the serializer is idle.
- `level` out $clog2(DEPTH+1): number of queued words, 0..DEPTH.
- `busy` out 1: a word is queued or `spi_tx` is mid-frame.

## Operation
- **Storage**: register array `mem[DEPTH]`, write pointer `wr_ptr` and read pointer `rd_ptr`. Each pointer is $clog2(DEPTH)+1 bits, with the MSB used as the wrap bit.
- **Empty/full**:
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
  - `level` = `wr_ptr - rd_ptr`, modulo 2^(AW+1).
- **Push**: occurs when `in_valid && in_ready`. `mem[wr_ptr[AW-1:0]] <= in_data` and `wr_ptr` increments.
- **`in_ready`** = !full. There is no write-through when full, even if a pop happens in the same cycle.
- **Pop**: occurs when `tx_valid && spi_ready`; `rd_ptr` increments. This is exactly the cycle in which `spi_tx` latches `BUS_DATA`.
- **Output drive**:
  - `tx_valid` = !empty.
  - `BUS_DATA` = `mem[rd_ptr[AW-1:0]]`, read combinationally from flops.
  - `BUS_DATA` is don't-care while empty; drive it to 0 for clean waveforms.
- **Simultaneous push and pop (not full)**: both pointers advance and `level` is unchanged.
- **Push into an empty FIFO**: there is no bypass. The word becomes visible on the next cycle.
- **`flush`**:
  - Both pointers are set to 0.
  - It takes priority over a push or pop in the same cycle, and any push in that cycle is discarded.
  - A frame `spi_tx` has already latched continues on the wire; `busy` reflects that frame.
- **`busy`** = !empty || !`spi_ready`.
- **Reset** (`RST` = 1 at a clk edge):
  - Pointers = 0, so `tx_valid` = 0, `level` = 0, `in_ready` = 1, `BUS_DATA` = 0.
  - `busy` follows `spi_ready`.
  - `mem` contents are not reset.
  - Reset mid-burst discards all queued words.

## Timing
- Push-to-`tx_valid` latency is 1 cycle: a word pushed at edge N gives `tx_valid` = 1 after edge N.
- `spi_tx` drops `spi_ready` in the cycle after it accepts a word. The FIFO therefore pops exactly once per frame, and the next head waits for `spi_ready` to return (about 24 × 24 + 30 clk later).
- `tx_valid` may be held high across the whole `spi_tx` frame. It never glitches low while words remain queued.
- Back-to-back pushes are accepted at 1 word/cycle until full. `in_ready` deasserts in the cycle after the DEPTH-th push.
- All outputs are functions of flops plus `spi_ready`. There is no combinational path from `in_valid` to `in_ready`.

## Structure
- Shared package `spi_pkg`:
  - `SPI_FRAME_W` = 24.
  - Frame typedef `spi_frame_t`, a DW-bit vector.
  - `SPI_FIFO_DEPTH_DEFAULT` = 8.
- One sub-module is natural: `sync_fifo` (generic DEPTH/DW, push/pop/flush, empty/full/level). `spi_tx_fifo` wraps it, maps pop to `tx_valid && spi_ready`, and generates `busy`.

## Test plan
- **Reset, then push one word**: `RST` high 2 cycles, then push 24'hA5_0F3C. Expect `tx_valid` = 1 on the next cycle with `BUS_DATA` = 24'hA5_0F3C. After `spi_ready` goes high: one pop, `level` returns to 0, and `spi_tx` shifts out A50F3C MSB-first.
- **Fill to full**: push 8 words 24'h000001..24'h000008 back-to-back with `spi_ready` held low. Expect `level` = 8 and `in_ready` = 0. A 9th push attempt is ignored. Then drain through a `spi_tx` model: frames arrive in order 1..8 and each pops exactly once.
- **Simultaneous push/pop**: at `level` = 3, push and pop in the same cycle. Expect `level` stays 3. Then run 20 mixed ops so the pointers wrap past DEPTH twice, and check no reordering.
- **Flush with concurrent push**: at `level` = 5 and mid-frame (`spi_ready` = 0), assert `flush` together with `in_valid`. Expect `level` = 0 and `tx_valid` = 0 next cycle. `busy` stays 1 until `spi_ready` rises, and the in-flight frame completes intact.
- **Reset mid-burst**: at `level` = 4, assert `RST` for 1 cycle. Expect `tx_valid` = 0, `level` = 0, `in_ready` = 1. The next push of 24'h123456 is the first frame sent.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Brief    : Shared SPI frame width, frame type and FIFO depth default.
// Revision : 1.0
// ============================================================================
package spi_pkg;

  localparam int SPI_FRAME_W            = 24;
  localparam int SPI_FIFO_DEPTH_DEFAULT = 8;

  typedef logic [SPI_FRAME_W-1:0] spi_frame_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Generic single-clock FIFO with wrap-bit pointers and flush.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 24
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DW-1:0]              wr_data,
  input  logic                       pop,
  output logic [DW-1:0]              rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [DW-1:0] r_mem [DEPTH];

  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_diff;

  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                  (r_wr_ptr[AW] != r_rd_ptr[AW]);
  // A pop never frees space for a same-cycle push: no write-through when full.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign w_diff = r_wr_ptr - r_rd_ptr;
  assign level  = LW'(w_diff);

  assign rd_data = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (RST || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush && !RST) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/spi_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : spi_tx_fifo
// Brief    : Queues SPI frames and hands them one at a time to spi_tx.
// Revision : 1.0
// ============================================================================
module spi_tx_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = SPI_FIFO_DEPTH_DEFAULT,
  parameter int DW    = SPI_FRAME_W
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic [DW-1:0]              in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [DW-1:0]              BUS_DATA,
  output logic                       tx_valid,
  input  logic                       spi_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       busy
);

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign in_ready = !w_full;
  assign tx_valid = !w_empty;
  assign w_push   = in_valid && !w_full;
  // spi_tx latches BUS_DATA in exactly this cycle, then drops spi_ready.
  assign w_pop    = !w_empty && spi_ready;
  assign busy     = !w_empty || !spi_ready;

  sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk     (clk),
    .RST     (RST),
    .flush   (flush),
    .push    (w_push),
    .wr_data (in_data),
    .pop     (w_pop),
    .rd_data (BUS_DATA),
    .empty   (w_empty),
    .full    (w_full),
    .level   (level)
  );

endmodule : spi_tx_fifo
`default_nettype wire

// File: tb/tb_spi_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_tx_fifo
// Brief    : Self-checking bench: vector table, corner sequences, random vs queue model.
// Revision : 1.0
// ============================================================================
module tb_spi_tx_fifo;
  import spi_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       RST;
  spi_frame_t in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  spi_frame_t BUS_DATA;
  logic       tx_valid;
  logic       spi_ready;
  logic [3:0] level;
  logic       busy;

  int errors = 0;
  int checks = 0;

  spi_tx_fifo #(.DEPTH(DEPTH), .DW(SPI_FRAME_W)) dut (
    .clk       (clk),
    .RST       (RST),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .BUS_DATA  (BUS_DATA),
    .tx_valid  (tx_valid),
    .spi_ready (spi_ready),
    .level     (level),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [23:0] d;
    logic        sr;
    logic        e_tv;
    logic [23:0] e_bd;
    logic [3:0]  e_lvl;
    logic        e_ir;
    logic        e_busy;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; in_valid = 1'b0; flush = 1'b0; in_data = '0;
    tick();
    tick();
    RST = 1'b0;
    #1;
  endtask

  task automatic push_word(input logic [23:0] d);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Serializer stand-in: waits for a head, accepts it, shifts it out MSB-first.
  task automatic send_frame(output logic [23:0] rebuilt);
    logic [23:0] shreg;
    logic [3:0]  lvl_before;
    bit          seen;
    rebuilt = '0;
    seen = 0;
    in_valid = 1'b0;
    spi_ready = 1'b1;
    #1;
    for (int i = 0; i < 50; i++) begin
      if (tx_valid) begin seen = 1; break; end
      tick();
    end
    if (!seen) begin
      chk("send_frame_timeout", 32'd0, 32'd1);
      return;
    end
    shreg = BUS_DATA;
    lvl_before = level;
    tick();
    spi_ready = 1'b0;
    #1;
    chk("pop_once_level", {28'd0, level}, {28'd0, lvl_before - 4'd1});
    chk("tv_no_glitch", {31'd0, tx_valid}, {31'd0, lvl_before > 4'd1});
    chk("busy_mid_frame", {31'd0, busy}, 32'd1);
    for (int b = 0; b < 24; b++) begin
      rebuilt = {rebuilt[22:0], shreg[23]};
      shreg   = {shreg[22:0], 1'b0};
      tick();
    end
    chk("level_held_mid_frame", {28'd0, level}, {28'd0, lvl_before - 4'd1});
    spi_ready = 1'b1;
    #1;
  endtask

  initial begin
    logic [23:0] got;
    spi_frame_t  q[$];
    int          pv;
    int          pr;
    bit          do_pop;
    bit          do_push;

    RST = 1'b1; in_valid = 1'b0; flush = 1'b0; in_data = '0; spi_ready = 1'b0;

    // ---------------- reset state ----------------
    do_reset();
    chk("rst_tv",   {31'd0, tx_valid}, 32'd0);
    chk("rst_lvl",  {28'd0, level},    32'd0);
    chk("rst_ir",   {31'd0, in_ready}, 32'd1);
    chk("rst_bd",   {8'd0, BUS_DATA},  32'd0);
    chk("rst_busy_sr0", {31'd0, busy}, 32'd1);
    spi_ready = 1'b1; #1;
    chk("rst_busy_sr1", {31'd0, busy}, 32'd0);
    spi_ready = 1'b0; #1;

    // ---------------- vector table ----------------
    //            fl  iv  d            sr   tv  bd           lvl ir  busy
    vecs[0] = '{1'b0,1'b1,24'hA50F3C,1'b0, 1'b0,24'h000000,4'd0,1'b1,1'b1};
    vecs[1] = '{1'b0,1'b0,24'h000000,1'b0, 1'b1,24'hA50F3C,4'd1,1'b1,1'b1};
    vecs[2] = '{1'b0,1'b0,24'h000000,1'b1, 1'b1,24'hA50F3C,4'd1,1'b1,1'b1};
    vecs[3] = '{1'b0,1'b0,24'h000000,1'b1, 1'b0,24'h000000,4'd0,1'b1,1'b0};
    vecs[4] = '{1'b0,1'b1,24'h111111,1'b1, 1'b0,24'h000000,4'd0,1'b1,1'b0};
    vecs[5] = '{1'b0,1'b1,24'h222222,1'b1, 1'b1,24'h111111,4'd1,1'b1,1'b1};
    vecs[6] = '{1'b0,1'b0,24'h000000,1'b0, 1'b1,24'h222222,4'd1,1'b1,1'b1};
    vecs[7] = '{1'b1,1'b1,24'h333333,1'b0, 1'b1,24'h222222,4'd1,1'b1,1'b1};
    vecs[8] = '{1'b0,1'b0,24'h000000,1'b0, 1'b0,24'h000000,4'd0,1'b1,1'b1};
    vecs[9] = '{1'b0,1'b0,24'h000000,1'b1, 1'b0,24'h000000,4'd0,1'b1,1'b0};
    for (int i = 0; i < 10; i++) begin
      flush = vecs[i].fl; in_valid = vecs[i].iv; in_data = vecs[i].d; spi_ready = vecs[i].sr;
      #1;
      chk($sformatf("vec%0d_tv", i),   {31'd0, tx_valid}, {31'd0, vecs[i].e_tv});
      chk($sformatf("vec%0d_bd", i),   {8'd0, BUS_DATA},  {8'd0, vecs[i].e_bd});
      chk($sformatf("vec%0d_lvl", i),  {28'd0, level},    {28'd0, vecs[i].e_lvl});
      chk($sformatf("vec%0d_ir", i),   {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy},     {31'd0, vecs[i].e_busy});
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;

    // ---------------- single word through the serializer ----------------
    do_reset();
    spi_ready = 1'b0;
    push_word(24'hA50F3C);
    #1;
    chk("one_tv", {31'd0, tx_valid}, 32'd1);
    send_frame(got);
    chk("one_shifted", {8'd0, got}, 32'h00A50F3C);
    chk("one_lvl_end", {28'd0, level}, 32'd0);

    // ---------------- fill to full, then drain ----------------
    do_reset();
    spi_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      chk($sformatf("fill_ir_%0d", i), {31'd0, in_ready}, 32'd1);
      push_word(24'(i));
    end
    #1;
    chk("full_lvl", {28'd0, level}, 32'd8);
    chk("full_ir",  {31'd0, in_ready}, 32'd0);
    push_word(24'h000009);
    #1;
    chk("ninth_lvl", {28'd0, level}, 32'd8);
    chk("ninth_bd",  {8'd0, BUS_DATA}, 32'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      send_frame(got);
      chk($sformatf("drain_%0d", i), {8'd0, got}, 32'(i));
    end
    chk("drain_lvl", {28'd0, level}, 32'd0);
    chk("drain_tv",  {31'd0, tx_valid}, 32'd0);

    // ---------------- simultaneous push/pop at level 3 ----------------
    do_reset();
    spi_ready = 1'b0;
    push_word(24'h0000AA);
    push_word(24'h0000BB);
    push_word(24'h0000CC);
    #1;
    chk("pp_lvl_before", {28'd0, level}, 32'd3);
    in_valid = 1'b1; in_data = 24'h0000DD; spi_ready = 1'b1;
    tick();
    in_valid = 1'b0; spi_ready = 1'b0;
    #1;
    chk("pp_lvl_after", {28'd0, level}, 32'd3);
    chk("pp_head",      {8'd0, BUS_DATA}, 32'h0000BB);

    // ---------------- flush with concurrent push, mid-frame ----------------
    do_reset();
    spi_ready = 1'b1;
    push_word(24'h000010);
    in_valid = 1'b1; in_data = 24'h000011;
    tick();
    spi_ready = 1'b0;
    for (int i = 2; i <= 5; i++) push_word(24'(16 + i));
    #1;
    chk("fl_lvl_before", {28'd0, level}, 32'd5);
    flush = 1'b1; in_valid = 1'b1; in_data = 24'hDEAD00;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_lvl",  {28'd0, level},    32'd0);
    chk("fl_tv",   {31'd0, tx_valid}, 32'd0);
    chk("fl_ir",   {31'd0, in_ready}, 32'd1);
    chk("fl_busy", {31'd0, busy},     32'd1);
    tick(); tick();
    chk("fl_busy_held", {31'd0, busy}, 32'd1);
    spi_ready = 1'b1; #1;
    chk("fl_busy_done", {31'd0, busy}, 32'd0);

    // ---------------- reset mid-burst ----------------
    do_reset();
    spi_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(24'(32'h40 + i));
    #1;
    chk("rmb_lvl_before", {28'd0, level}, 32'd4);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk("rmb_tv",  {31'd0, tx_valid}, 32'd0);
    chk("rmb_lvl", {28'd0, level},    32'd0);
    chk("rmb_ir",  {31'd0, in_ready}, 32'd1);
    chk("rmb_bd",  {8'd0, BUS_DATA},  32'd0);
    push_word(24'h123456);
    send_frame(got);
    chk("rmb_first_frame", {8'd0, got}, 32'h00123456);

    // ---------------- randomized run against a queue model ----------------
    do_reset();
    q.delete();
    for (int c = 0; c < 600; c++) begin
      pv = (c < 300) ? 65 : 35;
      pr = (c < 300) ? 35 : 65;
      in_valid  = ($urandom_range(0, 99) < pv);
      in_data   = 24'($urandom);
      spi_ready = ($urandom_range(0, 99) < pr);
      flush     = ($urandom_range(0, 99) < 2);
      #1;
      chk("rnd_tv",   {31'd0, tx_valid}, {31'd0, q.size() != 0});
      chk("rnd_lvl",  {28'd0, level},    32'(q.size()));
      chk("rnd_ir",   {31'd0, in_ready}, {31'd0, q.size() < DEPTH});
      chk("rnd_busy", {31'd0, busy},     {31'd0, (q.size() != 0) || !spi_ready});
      chk("rnd_bd",   {8'd0, BUS_DATA},  {8'd0, (q.size() != 0) ? q[0] : 24'd0});
      if (flush) begin
        q.delete();
      end else begin
        do_pop  = (q.size() != 0) && spi_ready;
        do_push = in_valid && (q.size() < DEPTH);
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(in_data);
      end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_spi_tx_fifo
`default_nettype wire
